candy_sram: RTL and testbench

- Single-port-pair SRAM responder. It is the memory end of the candy core's sram_raddr/sram_rdata/sram_waddr/sram_wdata interface.
- Serves registered reads with one-cycle latency.
- Absorbs writes through a one-entry posted write buffer with byte enables.
- Forwards pending and same-cycle write data to reads, so the core always sees write-first coherent data.
- Keeps saturating access counters for bench and debug visibility.

---
 rtl/candy_sram.sv | 138 +++++++++++++
 tb/tb_candy_sram.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/candy_sram.sv
// candy_sram: memory end of the candy core SRAM interface. One-cycle registered
// reads, a one-entry posted write buffer, and write-first forwarding per byte lane.

module candy_sram_lane (
    input  logic       same_en,
    input  logic [7:0] same_byte,
    input  logic       buf_en,
    input  logic [7:0] buf_byte,
    input  logic [7:0] mem_byte,
    output logic [7:0] rd_byte,
    output logic       fwd
);
    // The youngest write wins: same-cycle write, then buffered write, then array.
    always_comb begin
        rd_byte = mem_byte;
        fwd     = 1'b0;
        if (same_en) begin
            rd_byte = same_byte;
            fwd     = 1'b1;
        end else if (buf_en) begin
            rd_byte = buf_byte;
            fwd     = 1'b1;
        end
    end
endmodule

module candy_sram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sram_re,
    input  logic [ADDR_W-1:0]   sram_raddr,
    output logic [DATA_W-1:0]   sram_rdata,
    output logic                sram_rvalid,
    input  logic                sram_we,
    input  logic [ADDR_W-1:0]   sram_waddr,
    input  logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W/8-1:0] sram_wbe,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    wr_count,
    output logic [CNT_W-1:0]    hit_count
);
    localparam int LANES = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [LANES-1:0]  wb_be;

    logic                       same_hit;
    logic                       buf_hit;
    logic [DATA_W-1:0]          mem_word;
    logic [LANES-1:0][7:0]      rd_bytes;
    logic [LANES-1:0]           fwd_lanes;
    logic                       any_fwd;
    logic                       vld_pipe;

    // Posted write buffer; a reset drops an uncommitted entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_be    <= '0;
        end else begin
            wb_valid <= sram_we;
            if (sram_we) begin
                wb_addr <= sram_waddr;
                wb_data <= sram_wdata;
                wb_be   <= sram_wbe;
            end
        end
    end

    // Array commit from the buffer; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wb_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (wb_be[i])
                    mem[wb_addr][8*i +: 8] <= wb_data[8*i +: 8];
            end
        end
    end

    assign mem_word = mem[sram_raddr];
    assign same_hit = sram_we && (sram_waddr == sram_raddr);
    assign buf_hit  = wb_valid && (wb_addr == sram_raddr);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        candy_sram_lane u_lane (
            .same_en   (same_hit && sram_wbe[i]),
            .same_byte (sram_wdata[8*i +: 8]),
            .buf_en    (buf_hit && wb_be[i]),
            .buf_byte  (wb_data[8*i +: 8]),
            .mem_byte  (mem_word[8*i +: 8]),
            .rd_byte   (rd_bytes[i]),
            .fwd       (fwd_lanes[i])
        );
    end

    assign any_fwd = |fwd_lanes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_rdata <= '0;
            vld_pipe   <= 1'b0;
        end else begin
            vld_pipe <= sram_re;
            if (sram_re)
                sram_rdata <= rd_bytes;
        end
    end

    assign sram_rvalid = vld_pipe;

    // Statistics counters saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count  <= '0;
            wr_count  <= '0;
            hit_count <= '0;
        end else begin
            if (sram_re && rd_count != CNT_MAX)
                rd_count <= rd_count + CNT_ONE;
            if (sram_we && wr_count != CNT_MAX)
                wr_count <= wr_count + CNT_ONE;
            if (sram_re && any_fwd && hit_count != CNT_MAX)
                hit_count <= hit_count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_candy_sram.sv
// Scoreboard bench for candy_sram: stimulus queues expected read data, a
// negedge monitor pops and checks whenever a response is due.

module tb_candy_sram;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk, rst;
    logic              sram_re, sram_we, sram_rvalid;
    logic [ADDR_W-1:0] sram_raddr, sram_waddr;
    logic [DATA_W-1:0] sram_rdata, sram_wdata;
    logic [3:0]        sram_wbe;
    logic [CNT_W-1:0]  rd_count, wr_count, hit_count;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          neq;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    candy_sram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .sram_re(sram_re), .sram_raddr(sram_raddr),
        .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid),
        .sram_we(sram_we), .sram_waddr(sram_waddr),
        .sram_wdata(sram_wdata), .sram_wbe(sram_wbe),
        .rd_count(rd_count), .wr_count(wr_count), .hit_count(hit_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // One clock of stimulus; a read queues the response due next cycle.
    task automatic step(input bit re, input logic [9:0] ra, input logic [31:0] exp, input bit neq,
                        input bit we, input logic [9:0] wa, input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        sram_re = re; sram_raddr = ra;
        sram_we = we; sram_waddr = wa; sram_wdata = wd; sram_wbe = be;
        if (re) begin
            e.cyc = cyc + 1; e.data = exp; e.neq = neq;
            q.push_back(e);
        end
        @(posedge clk); #1;
        sram_re = 0; sram_we = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        step(0, 0, 0, 0, 1, a, d, be);
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] exp);
        step(1, a, exp, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_pulse();
        rst = 1;
        @(negedge clk);
        check("rst_rvalid", {31'b0, sram_rvalid}, 0);
        check("rst_rdata", sram_rdata, 0);
        check("rst_rd_count", {28'b0, rd_count}, 0);
        check("rst_wr_count", {28'b0, wr_count}, 0);
        check("rst_hit_count", {28'b0, hit_count}, 0);
        @(posedge clk); #1;
        rst = 0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e = q.pop_front();
            tests++;
            if (sram_rvalid !== 1'b1) begin
                fails++;
                $display("FAIL rvalid cyc %0d: got %b want 1", cyc, sram_rvalid);
            end else if (mon_e.neq ? (sram_rdata === mon_e.data) : (sram_rdata !== mon_e.data)) begin
                fails++;
                $display("FAIL rdata cyc %0d: got %h want %s%h", cyc, sram_rdata,
                         mon_e.neq ? "not " : "", mon_e.data);
            end
        end else if (!rst && sram_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL spurious_rvalid cyc %0d: got %b want 0", cyc, sram_rvalid);
        end
    end

    initial begin
        rst = 1; sram_re = 0; sram_we = 0;
        sram_raddr = 0; sram_waddr = 0; sram_wdata = 0; sram_wbe = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset between capture and commit drops the write.
        wr(5, 32'h11223344, 4'hF);
        rst_pulse();
        step(1, 5, 32'h11223344, 1, 0, 0, 0, 0);
        idle();

        // Array read latency.
        rst_pulse();
        wr(3, 32'hDEADBEEF, 4'hF);
        idle(); idle();
        rd(3, 32'hDEADBEEF);
        check("basic_rd_count", {28'b0, rd_count}, 1);
        check("basic_wr_count", {28'b0, wr_count}, 1);
        check("basic_hit_count", {28'b0, hit_count}, 0);
        idle();

        // Forwarding from the posted buffer.
        rst_pulse();
        wr(7, 32'hAAAAAAAA, 4'hF);
        rd(7, 32'hAAAAAAAA);
        check("buf_hit_count", {28'b0, hit_count}, 1);
        idle();

        // Same-cycle partial write merged over committed data.
        rst_pulse();
        wr(9, 32'h0, 4'hF);
        idle(); idle();
        step(1, 9, 32'h00340078, 0, 1, 9, 32'h12345678, 4'b0101);
        idle();
        rd(9, 32'h00340078);
        check("merge_hit_count", {28'b0, hit_count}, 1);
        idle();

        // Back-to-back same address, then a no-lane write.
        rst_pulse();
        wr(2, 32'd1, 4'hF);
        wr(2, 32'd2, 4'hF);
        idle(); idle();
        rd(2, 32'd2);
        wr(2, 32'hFFFFFFFF, 4'h0);
        rd(2, 32'd2);
        check("b2b_wr_count", {28'b0, wr_count}, 3);
        check("b2b_hit_count", {28'b0, hit_count}, 0);
        idle();

        // Counter saturation and rdata hold after idle.
        rst_pulse();
        for (int i = 0; i < 20; i++) rd(2, 32'd2);
        check("sat_rd_count", {28'b0, rd_count}, 15);
        idle();
        idle();
        check("idle_rvalid", {31'b0, sram_rvalid}, 0);
        check("idle_rdata_hold", sram_rdata, 32'd2);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
